// File: rtl/fpau_pkg.sv
// Shared types and constants for the square-root unit front-end controller.
package fpau_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 3;

  localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fpau_sqrt_ctrl_if.sv
// Requester, unit and response signals of the sqrt controller.
interface fpau_sqrt_ctrl_if;
  import fpau_pkg::*;

  logic              req0;
  logic [SEL_W-1:0]  sel0;
  logic              req1;
  logic [SEL_W-1:0]  sel1;
  logic              gnt0;
  logic              gnt1;
  logic              fpu_start;
  logic [DATA_W-1:0] fpu_op;
  logic              fpu_done;
  logic [DATA_W-1:0] fpu_res;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  req0, sel0, req1, sel1, fpu_done, fpu_res, rsp_ready,
    output gnt0, gnt1, fpu_start, fpu_op, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport master (
    output req0, sel0, req1, sel1, fpu_done, fpu_res, rsp_ready,
    input  gnt0, gnt1, fpu_start, fpu_op, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

endinterface

// File: rtl/fpau_sqrt_ctrl_ufc.sv
// ufc: 3-bit unsigned integer to IEEE-754 single conversion (combinational).
module ufc
  import fpau_pkg::*;
(
  input  logic [SEL_W-1:0]  val,
  output logic [DATA_W-1:0] flt_c
);

  // Exponent from the leading one; remaining bits become the top mantissa bits.
  always_comb begin
    flt_c = '0;
    if (val[2]) begin
      flt_c = {1'b0, 8'd129, val[1:0], 21'd0};
    end else if (val[1]) begin
      flt_c = {1'b0, 8'd128, val[0], 22'd0};
    end else if (val[0]) begin
      flt_c = {1'b0, 8'd127, 23'd0};
    end
  end

endmodule

// File: rtl/fpau_sqrt_ctrl.sv
// Arbitrates two requesters onto a shared sqrt unit with zero bypass,
// timeout abort and a held response channel.
module fpau_sqrt_ctrl
  import fpau_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  fpau_sqrt_ctrl_if.slave  bus
);

  state_e            state_q, state_d;
  logic              id_q, id_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              win_id_c;
  logic [SEL_W-1:0]  win_sel_c;
  logic [DATA_W-1:0] win_flt_c;

  // On a tie the requester that was not served last wins.
  assign win_id_c  = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
  assign win_sel_c = win_id_c ? bus.sel1 : bus.sel0;

  ufc u_ufc (
    .val   (win_sel_c),
    .flt_c (win_flt_c)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    start_d = 1'b0;
    op_d    = '0;
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = ST_ISSUE;
          id_d    = win_id_c;
          sel_d   = win_sel_c;
          gnt0_d  = ~win_id_c;
          gnt1_d  = win_id_c;
          op_d    = win_flt_c;
          start_d = (win_sel_c != '0);
        end
      end
      ST_ISSUE: begin
        if (sel_q != '0) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          // sqrt(0) is known without involving the unit
          state_d = ST_RESP;
          valid_d = 1'b1;
          data_d  = '0;
          err_d   = 1'b0;
        end
      end
      ST_WAIT: begin
        if (bus.fpu_done) begin
          state_d = ST_RESP;
          valid_d = 1'b1;
          data_d  = bus.fpu_res;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_RESP;
          valid_d = 1'b1;
          data_d  = QNAN;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          last_d  = id_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      id_q    <= 1'b0;
      sel_q   <= '0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      start_q <= 1'b0;
      op_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      start_q <= start_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.fpu_start = start_q;
  assign bus.fpu_op    = op_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = busy_q;

endmodule
